// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: sequences one critical-word-first wrapping burst
// refill per tag miss and steers the refill line buffer.
module cache_refill_ctrl #(
  parameter int DW        = 64,
  parameter int LINE_DW   = 256,
  parameter int OFFSET_DW = 5,
  parameter int BURST_DW  = 2,
  parameter int BLOCK_DW  = 4,
  parameter int AW        = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [AW-1:0]       miss_addr,
  input  logic                miss_read,
  output logic                cache2mem_cmd_valid,
  input  logic                cache2mem_cmd_ready,
  output logic [AW-1:0]       cache2mem_cmd_addr,
  output logic [BURST_DW-1:0] cache2mem_cmd_len,
  input  logic                cache2mem_rsp_valid,
  output logic [BURST_DW-1:0] rsp_burst_cnt,
  output logic [BLOCK_DW-1:0] offset_mux_sel,
  output logic                burst_pre_go_on,
  output logic                burst_pre_rsp_vld,
  output logic                refill_wr_en,
  output logic                rsp_burst_done_neg,
  output logic                busy
);

  localparam int unused_beats = LINE_DW / DW;
  localparam int PAD_W = OFFSET_DW - BURST_DW;
  localparam logic [BURST_DW-1:0] LAST = BURST_DW'(BLOCK_DW - 1);
  localparam logic [BLOCK_DW-1:0] ONE  = BLOCK_DW'(1);

  typedef enum logic [2:0] {
    IDLE, CMD, DATA, FILL, DONE
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [AW-1:0]       cmd_addr_q, cmd_addr_d;
  logic [BURST_DW-1:0] cnt_q, cnt_d;
  logic [BLOCK_DW-1:0] sel_q, sel_d;
  logic                read_q, read_d;
  logic                go_on_q, go_on_d;
  logic                pre_q, pre_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;

  logic [BURST_DW-1:0] crit_idx;
  logic                unused_addr_lsb;

  assign crit_idx = miss_addr[OFFSET_DW-1:PAD_W];
  assign unused_addr_lsb = ^miss_addr[PAD_W-1:0];

  // Next-state and registered-output decode for the refill sequence
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    read_d      = read_q;
    go_on_d     = 1'b0;
    pre_d       = go_on_q & read_q;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_valid) begin
          state_d     = CMD;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = {miss_addr[AW-1:OFFSET_DW],
                         crit_idx, {PAD_W{1'b0}}};
          sel_d       = ONE << crit_idx;
          read_d      = miss_read;
        end
      end
      CMD: begin
        if (cache2mem_cmd_ready) begin
          state_d     = DATA;
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      DATA: begin
        if (cache2mem_rsp_valid) begin
          go_on_d = (cnt_q == '0);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = FILL;
            wr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + BURST_DW'(1);
          end
        end
      end
      FILL: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any refill in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      read_q      <= 1'b0;
      go_on_q     <= 1'b0;
      pre_q       <= 1'b0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      read_q      <= read_d;
      go_on_q     <= go_on_d;
      pre_q       <= pre_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
    end
  end

  assign miss_ready          = (state_q == IDLE);
  assign busy                = (state_q != IDLE);
  assign cache2mem_cmd_valid = cmd_valid_q;
  assign cache2mem_cmd_addr  = cmd_addr_q;
  assign cache2mem_cmd_len   = LAST;
  assign rsp_burst_cnt       = cnt_q;
  assign offset_mux_sel      = sel_q;
  assign burst_pre_go_on     = go_on_q;
  assign burst_pre_rsp_vld   = pre_q;
  assign refill_wr_en        = wr_q;
  assign rsp_burst_done_neg  = done_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed checks of the refill sequencer.
// Inputs change #1 after a rising edge; outputs sampled there too.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        miss_valid = 1'b0;
  logic        miss_ready;
  logic [31:0] miss_addr = '0;
  logic        miss_read = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_len;
  logic        rsp_valid = 1'b0;
  logic [1:0]  cnt;
  logic [3:0]  sel;
  logic        go_on;
  logic        pre;
  logic        wr_en;
  logic        done_neg;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int nb;
  int go_n;
  int pre_n;
  int wr_n;
  logic [11:0] pat;

  cache_refill_ctrl dut (
    .clk                 (clk),
    .rstn                (rstn),
    .miss_valid          (miss_valid),
    .miss_ready          (miss_ready),
    .miss_addr           (miss_addr),
    .miss_read           (miss_read),
    .cache2mem_cmd_valid (cmd_valid),
    .cache2mem_cmd_ready (cmd_ready),
    .cache2mem_cmd_addr  (cmd_addr),
    .cache2mem_cmd_len   (cmd_len),
    .cache2mem_rsp_valid (rsp_valid),
    .rsp_burst_cnt       (cnt),
    .offset_mux_sel      (sel),
    .burst_pre_go_on     (go_on),
    .burst_pre_rsp_vld   (pre),
    .refill_wr_en        (wr_en),
    .rsp_burst_done_neg  (done_neg),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(miss_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cv"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_ca"}, cmd_addr, 32'd0);
    chk({tag, "_len"}, 32'(cmd_len), 32'd3);
    chk({tag, "_cnt"}, 32'(cnt), 32'd0);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_pulses"},
        32'({go_on, pre, wr_en, done_neg}), 32'd0);
  endtask

  initial begin
    // reset values
    #2;
    chk_reset_vals("rst");
    tick;
    rstn = 1'b1;

    // read miss 0x1018, immediate cmd_ready, back-to-back beats
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_1018;
    miss_read  = 1'b1;
    tick;
    miss_valid = 1'b0;
    chk("rd_cv", 32'(cmd_valid), 32'd1);
    chk("rd_ca", cmd_addr, 32'h0000_1018);
    chk("rd_len", 32'(cmd_len), 32'd3);
    chk("rd_sel", 32'(sel), 32'b1000);
    chk("rd_rdy", 32'(miss_ready), 32'd0);
    chk("rd_busy", 32'(busy), 32'd1);
    cmd_ready = 1'b1;
    tick;
    cmd_ready = 1'b0;
    chk("rd_cv_off", 32'(cmd_valid), 32'd0);
    chk("rd_cnt0", 32'(cnt), 32'd0);
    rsp_valid = 1'b1;
    tick;
    chk("rd_cnt1", 32'(cnt), 32'd1);
    chk("rd_go", 32'(go_on), 32'd1);
    chk("rd_pre_early", 32'(pre), 32'd0);
    tick;
    chk("rd_cnt2", 32'(cnt), 32'd2);
    chk("rd_go_off", 32'(go_on), 32'd0);
    chk("rd_pre", 32'(pre), 32'd1);
    tick;
    chk("rd_cnt3", 32'(cnt), 32'd3);
    chk("rd_pre_off", 32'(pre), 32'd0);
    tick;
    rsp_valid = 1'b0;
    chk("rd_cnt_wrap", 32'(cnt), 32'd0);
    chk("rd_wr", 32'(wr_en), 32'd1);
    chk("rd_done_early", 32'(done_neg), 32'd0);
    tick;
    chk("rd_wr_off", 32'(wr_en), 32'd0);
    chk("rd_done", 32'(done_neg), 32'd1);
    chk("rd_rdy_late", 32'(miss_ready), 32'd0);
    tick;
    chk("rd_done_off", 32'(done_neg), 32'd0);
    chk("rd_idle", 32'(miss_ready), 32'd1);
    chk("rd_sel_hold", 32'(sel), 32'b1000);

    // stray beats in IDLE
    rsp_valid = 1'b1;
    tick;
    chk("idle_cnt", 32'(cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pulses",
        32'({go_on, pre, wr_en, done_neg}), 32'd0);

    // write miss 0x2000, cmd_ready after 5 cycles, stray beats in CMD
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_2000;
    miss_read  = 1'b0;
    tick;
    miss_valid = 1'b0;
    chk("wr_sel", 32'(sel), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      chk("wr_cv_wait", 32'(cmd_valid), 32'd1);
      chk("wr_ca_wait", cmd_addr, 32'h0000_2000);
      chk("wr_len_wait", 32'(cmd_len), 32'd3);
      chk("cmd_stray_cnt", 32'(cnt), 32'd0);
      chk("cmd_stray_go", 32'(go_on), 32'd0);
      tick;
    end
    rsp_valid = 1'b0;
    chk("wr_cv_6", 32'(cmd_valid), 32'd1);
    chk("wr_ca_6", cmd_addr, 32'h0000_2000);
    cmd_ready = 1'b1;
    tick;
    cmd_ready = 1'b0;
    chk("wr_cv_off", 32'(cmd_valid), 32'd0);
    go_n = 0;
    pre_n = 0;
    wr_n = 0;
    rsp_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick;
      if (i == 3) rsp_valid = 1'b0;
      go_n += int'(go_on);
      pre_n += int'(pre);
      wr_n += int'(wr_en);
    end
    chk("wr_go_once", 32'(go_n), 32'd1);
    chk("wr_no_pre", 32'(pre_n), 32'd0);
    chk("wr_wr_once", 32'(wr_n), 32'd1);
    chk("wr_idle", 32'(miss_ready), 32'd1);

    // gapped beats; a second miss held valid throughout
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_3008;
    miss_read  = 1'b1;
    tick;
    miss_addr  = 32'h0000_4010;
    chk("gap_sel", 32'(sel), 32'b0010);
    chk("gap_ca", cmd_addr, 32'h0000_3008);
    chk("gap_rdy", 32'(miss_ready), 32'd0);
    cmd_ready = 1'b1;
    tick;
    cmd_ready = 1'b0;
    pat = 12'b0010_0011_0010;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      rsp_valid = pat[i];
      if (pat[i]) nb++;
      tick;
      rsp_valid = 1'b0;
      chk("gap_cnt", 32'(cnt), 32'(nb % 4));
      chk("gap_wr", 32'(wr_en), 32'(pat[i] && nb == 4));
      chk("gap_go", 32'(go_on), 32'(i == 1));
      chk("gap_pre", 32'(pre), 32'(i == 2));
      chk("gap_done", 32'(done_neg), 32'(i == 10));
      chk("gap_rdy_hold", 32'(miss_ready), 32'(i == 11));
    end
    chk("gap_sel_hold", 32'(sel), 32'b0010);
    tick;
    miss_valid = 1'b0;
    chk("b_sel", 32'(sel), 32'b0100);
    chk("b_ca", cmd_addr, 32'h0000_4010);
    chk("b_cv", 32'(cmd_valid), 32'd1);

    // reset after beat 1 of the second miss
    cmd_ready = 1'b1;
    tick;
    cmd_ready = 1'b0;
    rsp_valid = 1'b1;
    tick;
    tick;
    rsp_valid = 1'b0;
    chk("b_cnt2", 32'(cnt), 32'd2);
    chk("b_pre", 32'(pre), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    rstn = 1'b1;
    rsp_valid = 1'b1;
    tick;
    tick;
    rsp_valid = 1'b0;
    chk("post_rst_cnt", 32'(cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wr", 32'(wr_en), 32'd0);

    // normal refill after reset
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_5000;
    miss_read  = 1'b0;
    tick;
    miss_valid = 1'b0;
    chk("c_sel", 32'(sel), 32'b0001);
    chk("c_ca", cmd_addr, 32'h0000_5000);
    cmd_ready = 1'b1;
    tick;
    cmd_ready = 1'b0;
    rsp_valid = 1'b1;
    tick;
    chk("c_go", 32'(go_on), 32'd1);
    tick;
    chk("c_no_pre", 32'(pre), 32'd0);
    tick;
    tick;
    rsp_valid = 1'b0;
    chk("c_wr", 32'(wr_en), 32'd1);
    tick;
    chk("c_done", 32'(done_neg), 32'd1);
    tick;
    chk("c_idle", 32'(miss_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Sequencer for the cache line-refill path on a tag miss. It accepts one miss at a time and issues a single critical-word-first wrapping burst read to memory. It tracks response beats and drives the beat counter, block select, pre-response and completion strobes that steer the refill line buffer. It sits between the cache tag/miss logic and the memory-side burst port, alongside the refill line buffer and the response reorder mux.

## Interface
- DW, 64, memory beat width in bits
- LINE_DW, 256, cache line width in bits
- OFFSET_DW, 5, byte-offset bits within a line
- BURST_DW, 2, beat-counter width; equals log2(LINE_DW/DW)
- BLOCK_DW, 4, beats per line (LINE_DW/DW)
- AW, 32, address width
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous active-low reset
- miss_valid  in  1  miss request present
- miss_ready  out  1  controller idle; miss accepted when miss_valid & miss_ready
- miss_addr  in  AW  byte address of missing access
- miss_read  in  1  1 = read miss (core awaits pre-response), 0 = write miss
- cache2mem_cmd_valid  out  1  burst read command valid
- cache2mem_cmd_ready  in  1  memory accepts command
- cache2mem_cmd_addr  out  AW  critical-beat address: {miss_addr[AW-1:OFFSET_DW], crit_idx, zeros}
- cache2mem_cmd_len  out  BURST_DW  constant BLOCK_DW-1
- cache2mem_rsp_valid  in  1  response beat valid (no backpressure)
- rsp_burst_cnt  out  BURST_DW  index of the beat currently on the response bus
- offset_mux_sel  out  BLOCK_DW  one-hot of critical block index crit_idx
- burst_pre_go_on  out  1  one-cycle pulse: critical beat is in the line buffer
- burst_pre_rsp_vld  out  1  one-cycle pulse: registered pre-response valid to core (read misses only)
- refill_wr_en  out  1  one-cycle pulse: full line buffer ready to write to the array
- rsp_burst_done_neg  out  1  one-cycle pulse: refill complete; clears fill-block flags
- busy  out  1  state != IDLE

## Operation
- crit_idx = miss_addr[OFFSET_DW-1 : OFFSET_DW-BURST_DW]. It is captured at accept, together with the line address and miss_read.
- States: IDLE, CMD, DATA, FILL, DONE.
- IDLE: miss_ready=1. On accept, capture the request, load offset_mux_sel = 1<<crit_idx and go to CMD.
- CMD: cmd_valid=1 with a stable addr/len until cmd_ready. On the handshake cycle go to DATA with rsp_burst_cnt=0.
- DATA: each rsp_valid increments rsp_burst_cnt (mod BLOCK_DW). A beat with rsp_burst_cnt==BLOCK_DW-1 goes to FILL and the counter wraps to 0.
- FILL: refill_wr_en=1 for one cycle, then go to DONE.
- DONE: rsp_burst_done_neg=1 for one cycle, then go to IDLE.
- Pre-response:
  - The cycle after the beat with rsp_burst_cnt==0 is accepted, burst_pre_go_on=1 for one cycle, regardless of miss_read.
  - In the next cycle, burst_pre_rsp_vld=1 for one cycle only if the captured miss_read=1.
  - For BLOCK_DW=1 this pulse may overlap FILL/DONE; it must still fire exactly once.
- rsp_valid in IDLE, CMD, FILL or DONE is ignored: no counter or state change.
- offset_mux_sel holds its value until the next accept. It is not cleared in IDLE.
- cmd_ready while cmd_valid=0 has no effect.
- A miss presented during busy is not accepted (miss_ready=0). The requester holds it.

## Timing
- Reset values:
  - state IDLE, so miss_ready=1 and busy=0.
  - cmd_valid=0, cmd_addr=0, cmd_len=BLOCK_DW-1.
  - rsp_burst_cnt=0, offset_mux_sel=0.
  - All pulse outputs 0.
- Reset mid-operation aborts immediately to IDLE. Later stray rsp_valid beats are ignored.
- Accept at edge T: cmd_valid=1 from cycle T+1. Minimum accept-to-command latency is 1 cycle.
- Back-to-back beats are supported. Idle gaps between beats are allowed and the counter holds.
- Critical beat accepted at edge E: burst_pre_go_on high in cycle E+1, burst_pre_rsp_vld high in cycle E+2.
- Last beat at edge L: refill_wr_en in cycle L+1, rsp_burst_done_neg in cycle L+2, miss_ready=1 in cycle L+3.
- All outputs are registered or decoded from state only. There is no combinational path from input to output, except that miss_ready is decoded from state.

## Test plan
- Read miss, addr=0x0000_1018 (crit_idx=3), cmd_ready immediate, 4 back-to-back beats:
  - cmd_addr=0x0000_1018, len=3, offset_mux_sel=4'b1000.
  - rsp_burst_cnt 0,1,2,3 on the beats.
  - go_on pulse 1 cycle after beat 0, pre_rsp_vld 1 cycle later.
  - wr_en after beat 3, done_neg the following cycle.
- Write miss, addr=0x2000 (crit_idx=0), cmd_ready delayed 5 cycles:
  - cmd fields stable for all 6 valid cycles.
  - go_on pulses once; pre_rsp_vld never asserts.
- Gapped beats (rsp_valid on cycles 1,4,5,9) -> counter advances only on valid beats; wr_en one cycle after the 4th beat.
- Stray rsp_valid in IDLE and CMD -> rsp_burst_cnt stays 0; no pulses.
- Second miss held valid during busy -> miss_ready=0 until 3 cycles after the last beat; then it is accepted and offset_mux_sel updates to the new one-hot.
- rstn asserted after beat 1 -> all outputs at reset values the same cycle; the next miss completes a normal 4-beat refill.
